// File: rtl/btb_pkg.sv
// Shared types and tree-PLRU helpers for the set-associative BTB.
// Entry counters are only meaningful when BTB_COUNTER_EN is defined.
package btb_pkg;

    localparam int BTB_MAX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic                 jmp;
        logic [1:0]           ctr;
        logic [BTB_MAX_W-1:0] tag;
        logic [BTB_MAX_W-1:0] target;
    } btb_entry_t;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2, bit=1 means go right.
    function automatic logic [6:0] plru_touch(
        input logic [6:0] st,
        input logic [2:0] way,
        input int         lv
    );
        logic [6:0] n;
        int         node;
        logic       d;
        n    = st;
        node = 0;
        for (int l = 0; l < 3; l++) begin
            if (l < lv) begin
                d             = way[lv-1-l];
                n[node[2:0]]  = ~d;
                node          = 2 * node + 1 + int'(d);
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] plru_victim(
        input logic [6:0] st,
        input int         lv
    );
        int node;
        node = 0;
        for (int l = 0; l < 3; l++) begin
            if (l < lv) begin
                node = 2 * node + 1 + int'(st[node[2:0]]);
            end
        end
        return 3'(node - ((1 << lv) - 1));
    endfunction

endpackage

// File: rtl/btb_plru.sv
// Per-set tree pseudo-LRU state; a direct-mapped BTB keeps no state.
// Clear has priority over a touch in the same cycle.
module btb_plru
    import btb_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_touch,
    input  logic [WW-1:0] i_way,
    output logic [WW-1:0] o_victim
);

    generate
        if (WAYS == 1) begin : g_dm
            assign o_victim = '0;
        end else begin : g_tree
            localparam int LV = $clog2(WAYS);
            logic [WAYS-2:0] r_bits;
            logic [6:0]      w_st;
            logic [6:0]      w_nx;
            logic [2:0]      w_vic;

            assign w_st     = 7'(r_bits);
            assign w_nx     = plru_touch(w_st, 3'(i_way), LV);
            assign w_vic    = plru_victim(w_st, LV);
            assign o_victim = w_vic[WW-1:0];

            always_ff @(posedge clk) begin
                if (!rst_n || i_clr) begin
                    r_bits <= '0;
                end else if (i_touch) begin
                    r_bits <= w_nx[WAYS-2:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer, 1-cycle lookup, read-before-write.
// Define BTB_COUNTER_EN for per-entry 2-bit taken counters.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int ENTRIES = 128,
    parameter int WAYS    = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [ADDR_W-1:0] resp_target,
    output logic              resp_jmp,
    output logic              resp_taken,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_jmp,
    input  logic              upd_taken,
    input  logic              flush
);

    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    btb_entry_t r_ent [SETS][WAYS];

    logic [IDX_W-1:0]     w_lidx, w_uidx;
    logic [BTB_MAX_W-1:0] w_ltag, w_utag;
    logic                 w_lhit, w_uhit, w_ifree;
    logic [WW-1:0]        w_lway, w_uway, w_iway, w_sel;
    logic [WW-1:0]        w_vic [SETS];
    logic [WW-1:0]        w_twy [SETS];
    logic [SETS-1:0]      w_touch;
    logic                 w_wr, w_inv, w_lhit_v;
    btb_entry_t           w_lent, w_new;

    assign w_lidx = lookup_pc[IDX_W+1:2];
    assign w_uidx = upd_pc[IDX_W+1:2];
    assign w_ltag = BTB_MAX_W'(lookup_pc[ADDR_W-1:IDX_W+2]);
    assign w_utag = BTB_MAX_W'(upd_pc[ADDR_W-1:IDX_W+2]);

    always_comb begin
        w_lhit  = 1'b0;
        w_lway  = '0;
        w_uhit  = 1'b0;
        w_uway  = '0;
        w_ifree = 1'b0;
        w_iway  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_ent[w_lidx][w].valid && r_ent[w_lidx][w].tag == w_ltag) begin
                w_lhit = 1'b1;
                w_lway = WW'(w);
            end
            if (r_ent[w_uidx][w].valid && r_ent[w_uidx][w].tag == w_utag) begin
                w_uhit = 1'b1;
                w_uway = WW'(w);
            end
        end
        // Descending scan so the lowest-numbered free way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_ent[w_uidx][w].valid) begin
                w_ifree = 1'b1;
                w_iway  = WW'(w);
            end
        end
    end

    assign w_sel    = w_uhit ? w_uway : (w_ifree ? w_iway : w_vic[w_uidx]);
    assign w_lent   = r_ent[w_lidx][w_lway];
    assign w_lhit_v = lookup_valid & w_lhit;

`ifdef BTB_COUNTER_EN
    assign w_wr  = upd_valid & (upd_taken | w_uhit);
    assign w_inv = 1'b0;
`else
    assign w_wr  = upd_valid & upd_taken;
    assign w_inv = upd_valid & ~upd_taken & w_uhit;
`endif

    always_comb begin
        w_new       = r_ent[w_uidx][w_sel];
        w_new.valid = 1'b1;
        if (upd_taken) begin
            w_new.tag    = w_utag;
            w_new.target = BTB_MAX_W'(upd_target);
            w_new.jmp    = upd_jmp;
        end
`ifdef BTB_COUNTER_EN
        if (!w_uhit) begin
            w_new.ctr = 2'b10;
        end else if (upd_taken && w_new.ctr != 2'b11) begin
            w_new.ctr = w_new.ctr + 2'b01;
        end else if (!upd_taken && w_new.ctr != 2'b00) begin
            w_new.ctr = w_new.ctr - 2'b01;
        end
`else
        w_new.ctr = 2'b00;
`endif
    end

    // A write to a set overrides a lookup-hit touch of the same set.
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            w_touch[s] = 1'b0;
            w_twy[s]   = '0;
        end
        if (w_lhit_v) begin
            w_touch[w_lidx] = 1'b1;
            w_twy[w_lidx]   = w_lway;
        end
        if (w_wr) begin
            w_touch[w_uidx] = 1'b1;
            w_twy[w_uidx]   = w_sel;
        end
    end

    generate
        for (genvar s = 0; s < SETS; s++) begin : g_set
            btb_plru #(.WAYS(WAYS)) u_plru (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_clr    (flush),
                .i_touch  (w_touch[s]),
                .i_way    (w_twy[s]),
                .o_victim (w_vic[s])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_ent[s][w].valid <= 1'b0;
                    r_ent[s][w].ctr   <= 2'b00;
                end
            end
        end else if (w_wr) begin
            r_ent[w_uidx][w_sel] <= w_new;
        end else if (w_inv) begin
            r_ent[w_uidx][w_uway].valid <= 1'b0;
        end
    end

    logic              r_resp_valid, r_resp_hit, r_resp_jmp, r_resp_taken;
    logic [ADDR_W-1:0] r_resp_target;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_resp_valid  <= 1'b0;
            r_resp_hit    <= 1'b0;
            r_resp_jmp    <= 1'b0;
            r_resp_taken  <= 1'b0;
            r_resp_target <= '0;
        end else begin
            r_resp_valid  <= lookup_valid;
            r_resp_hit    <= w_lhit_v;
            r_resp_jmp    <= w_lhit_v & w_lent.jmp;
            r_resp_target <= w_lhit_v ? w_lent.target[ADDR_W-1:0] : '0;
`ifdef BTB_COUNTER_EN
            r_resp_taken  <= w_lhit_v & w_lent.ctr[1];
`else
            r_resp_taken  <= w_lhit_v;
`endif
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_hit    = r_resp_hit;
    assign resp_jmp    = r_resp_jmp;
    assign resp_taken  = r_resp_taken;
    assign resp_target = r_resp_target;

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc (default 128 entries, 2 ways); honours BTB_COUNTER_EN.
// Reference keeps each set as a recency-ordered list of at most two entries.
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        resp_valid, resp_hit, resp_jmp, resp_taken;
    logic [31:0] resp_target;
    logic        upd_valid;
    logic [31:0] upd_pc, upd_target;
    logic        upd_jmp, upd_taken, flush;

    int total = 0;
    int bad   = 0;

    btb_assoc #(.ENTRIES(128), .WAYS(2), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_target  (resp_target),
        .resp_jmp     (resp_jmp),
        .resp_taken   (resp_taken),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_jmp      (upd_jmp),
        .upd_taken    (upd_taken),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] key;
        logic [31:0] tgt;
        logic        jmp;
        logic [1:0]  ctr;
    } ment_t;

    // Index 0 is most recently used, index 1 is the eviction candidate.
    ment_t mq [64][2];
    int    mc [64];

    task automatic chk(input string tg, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tg, got, exp);
        end
    endtask

    function automatic int fnd(input int s, input logic [29:0] k);
        for (int i = 0; i < mc[s]; i++)
            if (mq[s][i].key == k) return i;
        return -1;
    endfunction

    task automatic front(input int s, input int p);
        ment_t t;
        if (p == 1) begin
            t        = mq[s][0];
            mq[s][0] = mq[s][1];
            mq[s][1] = t;
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < 64; s++) mc[s] = 0;
    endtask

    task automatic m_upd(input logic [31:0] pc, input logic [31:0] t,
                         input logic j, input logic tk, output bit wrote);
        int    s, p;
        ment_t n;
        s     = int'(pc[7:2]);
        p     = fnd(s, pc[31:2]);
        wrote = 0;
        n.key = pc[31:2];
        n.tgt = t;
        n.jmp = j;
        n.ctr = 2'b10;
`ifdef BTB_COUNTER_EN
        if (p >= 0) begin
            if (tk) begin
                mq[s][p].tgt = t;
                mq[s][p].jmp = j;
                if (mq[s][p].ctr != 2'b11) mq[s][p].ctr++;
            end else if (mq[s][p].ctr != 2'b00) begin
                mq[s][p].ctr--;
            end
            front(s, p);
            wrote = 1;
        end else if (tk) begin
            mq[s][1] = mq[s][0];
            mq[s][0] = n;
            if (mc[s] < 2) mc[s]++;
            wrote = 1;
        end
`else
        if (p >= 0 && tk) begin
            mq[s][p].tgt = t;
            mq[s][p].jmp = j;
            front(s, p);
            wrote = 1;
        end else if (p >= 0) begin
            if (p == 0) mq[s][0] = mq[s][1];
            mc[s]--;
        end else if (tk) begin
            mq[s][1] = mq[s][0];
            mq[s][0] = n;
            if (mc[s] < 2) mc[s]++;
            wrote = 1;
        end
`endif
    endtask

    task automatic cyc(input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc,
                       input logic [31:0] ut, input logic uj,
                       input logic utk, input logic fl);
        int          ls, lp;
        bit          ev, eh, et, ej, wr;
        logic [31:0] etg;
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_pc       = upc;
        upd_target   = ut;
        upd_jmp      = uj;
        upd_taken    = utk;
        flush        = fl;
        ls  = int'(lpc[7:2]);
        lp  = fnd(ls, lpc[31:2]);
        ev  = lv && !fl;
        eh  = ev && lp >= 0;
        etg = eh ? mq[ls][lp].tgt : 32'h0;
        ej  = eh && mq[ls][lp].jmp;
`ifdef BTB_COUNTER_EN
        et  = eh && mq[ls][lp].ctr[1];
`else
        et  = eh;
`endif
        @(posedge clk);
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        chk("resp_hit", 32'(resp_hit), 32'(eh));
        chk("resp_target", resp_target, etg);
        chk("resp_jmp", 32'(resp_jmp), 32'(ej));
        chk("resp_taken", 32'(resp_taken), 32'(et));
        if (fl) begin
            m_clear();
        end else begin
            wr = 0;
            if (uv) m_upd(upc, ut, uj, utk, wr);
            if (eh && !(wr && int'(upc[7:2]) == ls)) begin
                lp = fnd(ls, lpc[31:2]);
                if (lp >= 0) front(ls, lp);
            end
        end
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] t,
                       input logic tk);
        cyc(1'b0, 32'h0, 1'b1, pc, t, 1'b0, tk, 1'b0);
    endtask

    task automatic do_flush();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [31:0] rp, rq;

    initial begin
        rst_n        = 1'b0;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h1000;
        upd_valid    = 1'b0;
        upd_pc       = 32'h0;
        upd_target   = 32'h0;
        upd_jmp      = 1'b0;
        upd_taken    = 1'b0;
        flush        = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_hit", 32'(resp_hit), 32'h0);
        chk("rst_target", resp_target, 32'h0);
        chk("rst_taken", 32'(resp_taken), 32'h0);
        rst_n        = 1'b1;
        lookup_valid = 1'b0;

        look(32'h1000);
        upd(32'h1000, 32'h2000, 1'b1);
        look(32'h1000);
        chk("basic_target", resp_target, 32'h2000);
        upd(32'h1200, 32'h2200, 1'b1);
        look(32'h1000);
        chk("keep_old_way", 32'(resp_hit), 32'h1);
        look(32'h1200);
        chk("second_way", resp_target, 32'h2200);

        do_flush();
        upd(32'h1000, 32'hA000, 1'b1);
        upd(32'h1100, 32'hB000, 1'b1);
        look(32'h1000);
        upd(32'h1200, 32'hC000, 1'b1);
        look(32'h1000);
        chk("lru_a_hit", 32'(resp_hit), 32'h1);
        look(32'h1200);
        chk("lru_c_hit", 32'(resp_hit), 32'h1);
        look(32'h1100);
        chk("lru_b_miss", 32'(resp_hit), 32'h0);

        upd(32'h3000, 32'h3333, 1'b1);
        cyc(1'b1, 32'h3000, 1'b1, 32'h3000, 32'h4000, 1'b1, 1'b1, 1'b0);
        chk("rbw_old", resp_target, 32'h3333);
        look(32'h3000);
        chk("rbw_new", resp_target, 32'h4000);

        for (int i = 0; i < 4; i++)
            upd(32'h5000 + 32'(i * 4), 32'h600 + 32'(i), 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 32'h5010, 32'h777, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            look(32'h5000 + 32'(i * 4));
            chk("flush_miss", 32'(resp_hit), 32'h0);
        end

`ifdef BTB_COUNTER_EN
        upd(32'h7000, 32'h7100, 1'b1);
        upd(32'h7000, 32'h7100, 1'b0);
        upd(32'h7000, 32'h7100, 1'b0);
        look(32'h7000);
        chk("ctr_nt_hit", 32'(resp_hit), 32'h1);
        chk("ctr_nt_taken", 32'(resp_taken), 32'h0);
        upd(32'h7000, 32'h7100, 1'b1);
        upd(32'h7000, 32'h7100, 1'b1);
        look(32'h7000);
        chk("ctr_t_taken", 32'(resp_taken), 32'h1);
`else
        upd(32'h7000, 32'h7100, 1'b1);
        upd(32'h7000, 32'h7100, 1'b0);
        look(32'h7000);
        chk("nt_invalidates", 32'(resp_hit), 32'h0);
`endif

        for (int i = 0; i < 600; i++) begin
            rp = 32'h1000 + 32'($urandom_range(0, 3) << 8)
                 + 32'($urandom_range(0, 2) << 2);
            rq = 32'h1000 + 32'($urandom_range(0, 3) << 8)
                 + 32'($urandom_range(0, 2) << 2);
            cyc(1'($urandom_range(0, 9) < 7), rp,
                1'($urandom_range(0, 1)), rq, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter ENTRIES, default 128, meaning total entries (power of two, >= WAYS).
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity; legal values are 1, 2, 4 and 8.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning PC and target width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning synchronous, active-low reset.
REQ-006 SHALL have port lookup_valid, input, 1, meaning a lookup request.
REQ-007 SHALL have port lookup_pc, input, ADDR_W, meaning the fetch PC to look up.
REQ-008 SHALL have port resp_valid, output, 1, meaning the response is valid one cycle after lookup_valid.
REQ-009 SHALL have ports resp_hit (output, 1), resp_target (output, ADDR_W), resp_jmp (output, 1) and resp_taken (output, 1), meaning the hit flag, stored target, stored jump flag and predicted-taken flag.
REQ-010 SHALL have ports upd_valid (input, 1), upd_pc (input, ADDR_W), upd_target (input, ADDR_W), upd_jmp (input, 1) and upd_taken (input, 1), meaning the resolved-branch update from execute.
REQ-011 SHALL have port flush, input, 1, meaning invalidate all entries.

Function
REQ-012 SHALL use SETS = ENTRIES/WAYS, index = pc[IDX_W+1:2] with IDX_W = log2(SETS), and tag = pc[ADDR_W-1:IDX_W+2].
REQ-013 SHALL give each entry an explicit valid bit; a zero target is a legal stored value.
REQ-014 SHALL register the lookup with 1-cycle latency: resp_* reflect the lookup_pc sampled on the previous edge.
REQ-015 SHALL drive resp_hit=1 only when a valid way's tag matches; on a miss resp_target=0, resp_jmp=0 and resp_taken=0.
REQ-016 SHALL never produce multiple hits within a set, because an update always rewrites a matching way rather than allocating a new one.
REQ-017 SHALL, when upd_valid=1 and upd_taken=1, overwrite the matching way if one exists; otherwise allocate the lowest-numbered invalid way; otherwise replace the tree-PLRU victim.
REQ-018 SHALL not allocate on upd_valid=1 with upd_taken=0 and no matching way.
REQ-019 SHALL update the set's PLRU to point away from the way on each lookup hit and on each written way; when both target the same set in one cycle, the update wins.
REQ-020 SHALL make same-cycle lookup and update to the same entry read-before-write: the response shows the old contents, and the new contents are visible from the next lookup.
REQ-021 SHALL give flush the same effect as reset on valid bits and PLRU state, with priority over a same-cycle update; resp_valid is 0 in the cycle after a flush.
REQ-022 SHALL treat WAYS=1 as a direct-mapped BTB with no PLRU storage.

Reset
REQ-023 SHALL, while rst_n=0 at an edge, clear all valid bits, PLRU bits and counters, and drive resp_valid, resp_hit, resp_jmp, resp_taken and resp_target to 0.
REQ-024 SHALL discard a lookup in flight when reset is asserted; tag and target arrays need no reset.

Configuration
REQ-025 SHALL, with BTB_COUNTER_EN defined, add a 2-bit saturating counter per entry: initialised to 2'b10 on allocation; on a hit it is incremented when upd_taken=1 and decremented when upd_taken=0; resp_taken = hit & counter[1].
REQ-026 SHALL, without BTB_COUNTER_EN, have no counters: resp_taken = resp_hit, and an update with upd_taken=0 that matches a way invalidates that way.

Structure
REQ-027 SHALL place the entry struct typedef (tag, target, jmp, valid, counter) and the PLRU helper functions in package btb_pkg.
REQ-028 SHALL implement PLRU update and victim selection in sub-module btb_plru, instantiated once per set, parameterised by WAYS.

Verification
REQ-029 SHALL cover: reset, then lookup 0x0000_1000 -> next cycle resp_valid=1, resp_hit=0, resp_target=0.
REQ-030 SHALL cover: update pc=0x0000_1000, target=0x0000_2000, taken=1; then lookup 0x1000 -> resp_hit=1, resp_target=0x2000; lookup 0x0000_1200 (same index at default parameters, different tag) -> allocates or looks up in way 1 without evicting 0x1000.
REQ-031 SHALL cover (WAYS=2): fill a set with A and B, look up A, then insert C -> B is evicted; A and C hit and B misses.
REQ-032 SHALL cover: a same-cycle lookup and update of pc=0x3000 with new target 0x4000 -> the response shows the old target (or a miss), and the next lookup returns 0x4000.
REQ-033 SHALL cover: flush asserted after populating 4 entries -> all subsequent lookups miss; a flush in the same cycle as an update leaves that entry invalid.
REQ-034 SHALL cover (BTB_COUNTER_EN): allocate, then two not-taken updates -> resp_taken=0 while resp_hit=1; then two taken updates -> resp_taken=1.
